// File: rtl/mem_wb_stage.sv
// MEM stage of the 5-stage pipeline: data-memory load/store against an
// internal word-addressed RAM with multi-cycle access latency, branch/jump
// next-PC selection, and the MEM/WB pipeline boundary. Every register in
// this stage, including the RAM, updates on the falling edge of clk.
module mem_wb_stage #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        Branch_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Jump_in,
  input  logic [31:0] jump_addr_in,
  input  logic [31:0] branch_addr_in,
  input  logic        ALU_zero_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  EX_MEM_RegisterRd_in,
  output logic        mem_stall,
  output logic        PCSrc_out,
  output logic        Jump_taken_out,
  output logic [31:0] target_addr_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] read_data_out,
  output logic [31:0] ALU_result_out,
  output logic [4:0]  MEM_WB_RegisterRd_out,
  output logic        mem_err
);

  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        mem_q [DEPTH];

  logic               regwrite_q, regwrite_d;
  logic               memtoreg_q, memtoreg_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        alu_q, alu_d;
  logic [4:0]         rd_q, rd_d;
  logic               err_q, err_d;

  logic               idle;
  logic               req;
  logic               both_req;
  logic               misaligned;
  logic               valid_req;
  logic               access_done;
  logic               no_mem;
  logic [ADDR_W-1:0]  waddr;
  logic               unused_addr_bits;

  // Address bits above the RAM word index wrap around and are deliberately ignored.
  assign unused_addr_bits = ^ALU_result_in[31:ADDR_W+2];

  assign idle       = (state_q == IDLE);
  assign req        = MemRead_in ^ MemWrite_in;
  assign both_req   = MemRead_in & MemWrite_in;
  assign no_mem     = ~MemRead_in & ~MemWrite_in;
  assign misaligned = req & (ALU_result_in[1:0] != 2'b00);
  assign valid_req  = req & ~misaligned;
  assign waddr      = ALU_result_in[ADDR_W+1:2];

  // Access completes on this edge: single-cycle memory from IDLE, or the last BUSY cycle.
  assign access_done = (idle & valid_req & (LATENCY == 1)) |
                       (!idle & (cnt_q == CNT_W'(1)));

  // Stall, branch/jump resolution and next-PC target selection.
  always_comb begin
    mem_stall       = (idle & valid_req & (LATENCY > 1)) |
                      (!idle & (cnt_q > CNT_W'(1)));
    PCSrc_out       = Branch_in & ALU_zero_in & ~mem_stall;
    Jump_taken_out  = Jump_in & ~mem_stall;
    target_addr_out = 32'h0;
    if (Jump_taken_out)
      target_addr_out = jump_addr_in;
    else if (PCSrc_out)
      target_addr_out = branch_addr_in;
  end

  // Access FSM next state: arm the latency counter in IDLE, count down in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (valid_req && (LATENCY > 1)) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // MEM/WB next values: a bubble unless the stage passes through or an access completes.
  always_comb begin
    regwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    rdata_d    = 32'h0;
    alu_d      = 32'h0;
    rd_d       = 5'd0;
    err_d      = idle & (both_req | misaligned);
    if (access_done || (idle && no_mem)) begin
      regwrite_d = RegWrite_in;
      memtoreg_d = MemtoReg_in;
      alu_d      = ALU_result_in;
      rd_d       = EX_MEM_RegisterRd_in;
      if (access_done && MemRead_in)
        rdata_d = mem_q[waddr];
    end
  end

  // FSM and MEM/WB registers; reset aborts any access in flight.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      rdata_q    <= 32'h0;
      alu_q      <= 32'h0;
      rd_q       <= 5'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      rdata_q    <= rdata_d;
      alu_q      <= alu_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
    end
  end

  // Data RAM write: commits exactly once, on the completing edge of a store.
  always_ff @(negedge clk) begin
    if (!rst && access_done && MemWrite_in)
      mem_q[waddr] <= write_data_in;
  end

  assign RegWrite_out          = regwrite_q;
  assign MemtoReg_out          = memtoreg_q;
  assign read_data_out         = rdata_q;
  assign ALU_result_out        = alu_q;
  assign MEM_WB_RegisterRd_out = rd_q;
  assign mem_err               = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (LATENCY=2). Inputs change just after a
// falling edge and outputs are sampled a few ns later, well clear of the
// next falling edge.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Jump_in;
  logic [31:0] jump_addr_in, branch_addr_in, ALU_result_in, write_data_in;
  logic        ALU_zero_in;
  logic [4:0]  EX_MEM_RegisterRd_in;
  logic        mem_stall, PCSrc_out, Jump_taken_out;
  logic [31:0] target_addr_out;
  logic        RegWrite_out, MemtoReg_out;
  logic [31:0] read_data_out, ALU_result_out;
  logic [4:0]  MEM_WB_RegisterRd_out;
  logic        mem_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .Branch_in(Branch_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .Jump_in(Jump_in), .jump_addr_in(jump_addr_in), .branch_addr_in(branch_addr_in),
    .ALU_zero_in(ALU_zero_in), .ALU_result_in(ALU_result_in),
    .write_data_in(write_data_in), .EX_MEM_RegisterRd_in(EX_MEM_RegisterRd_in),
    .mem_stall(mem_stall), .PCSrc_out(PCSrc_out), .Jump_taken_out(Jump_taken_out),
    .target_addr_out(target_addr_out), .RegWrite_out(RegWrite_out),
    .MemtoReg_out(MemtoReg_out), .read_data_out(read_data_out),
    .ALU_result_out(ALU_result_out), .MEM_WB_RegisterRd_out(MEM_WB_RegisterRd_out),
    .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic set_idle();
    RegWrite_in = 0; MemtoReg_in = 0; Branch_in = 0; MemRead_in = 0;
    MemWrite_in = 0; Jump_in = 0; ALU_zero_in = 0;
    jump_addr_in = 0; branch_addr_in = 0; ALU_result_in = 0;
    write_data_in = 0; EX_MEM_RegisterRd_in = 0;
  endtask

  initial begin
    set_idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_stall", {31'b0, mem_stall}, 0);
    chk("rst_regwrite", {31'b0, RegWrite_out}, 0);
    chk("rst_rdata", read_data_out, 0);
    chk("rst_alu", ALU_result_out, 0);
    chk("rst_rd", {27'b0, MEM_WB_RegisterRd_out}, 0);
    chk("rst_err", {31'b0, mem_err}, 0);

    // Store 0xDEADBEEF to byte 0x10 (word 4)
    MemWrite_in = 1; ALU_result_in = 32'h10; write_data_in = 32'hDEADBEEF;
    #1 chk("st_stall_c0", {31'b0, mem_stall}, 1);
    tick();
    chk("st_stall_c1", {31'b0, mem_stall}, 0);
    chk("st_regwr_c1", {31'b0, RegWrite_out}, 0);
    tick();
    chk("st_regwr_done", {31'b0, RegWrite_out}, 0);
    chk("st_err", {31'b0, mem_err}, 0);

    // Load from 0x10 into r5
    set_idle();
    MemRead_in = 1; MemtoReg_in = 1; RegWrite_in = 1;
    EX_MEM_RegisterRd_in = 5'd5; ALU_result_in = 32'h10;
    #1 chk("ld_stall_c0", {31'b0, mem_stall}, 1);
    tick();
    chk("ld_stall_c1", {31'b0, mem_stall}, 0);
    chk("ld_bubble_regwr", {31'b0, RegWrite_out}, 0);
    tick();
    chk("ld_rdata", read_data_out, 32'hDEADBEEF);
    chk("ld_regwr", {31'b0, RegWrite_out}, 1);
    chk("ld_memtoreg", {31'b0, MemtoReg_out}, 1);
    chk("ld_rd", {27'b0, MEM_WB_RegisterRd_out}, 5);

    // R-type pass-through
    set_idle();
    RegWrite_in = 1; ALU_result_in = 32'h1234; EX_MEM_RegisterRd_in = 5'd3;
    #1 chk("rt_stall", {31'b0, mem_stall}, 0);
    tick();
    chk("rt_alu", ALU_result_out, 32'h1234);
    chk("rt_rd", {27'b0, MEM_WB_RegisterRd_out}, 3);
    chk("rt_rdata", read_data_out, 0);
    chk("rt_regwr", {31'b0, RegWrite_out}, 1);
    chk("rt_memtoreg", {31'b0, MemtoReg_out}, 0);

    // Misaligned store to 0x13
    set_idle();
    MemWrite_in = 1; RegWrite_in = 1; ALU_result_in = 32'h13; write_data_in = 32'h11111111;
    #1 chk("mis_stall", {31'b0, mem_stall}, 0);
    tick();
    chk("mis_err", {31'b0, mem_err}, 1);
    chk("mis_bubble", {31'b0, RegWrite_out}, 0);
    set_idle();
    tick();
    chk("mis_err_clr", {31'b0, mem_err}, 0);

    // Read and write together: error, no stall
    MemRead_in = 1; MemWrite_in = 1; RegWrite_in = 1; ALU_result_in = 32'h10;
    write_data_in = 32'h22222222;
    #1 chk("both_stall", {31'b0, mem_stall}, 0);
    tick();
    chk("both_err", {31'b0, mem_err}, 1);
    chk("both_bubble", {31'b0, RegWrite_out}, 0);

    // Load via wrapped address 0x410 (word 4): original data intact
    set_idle();
    MemRead_in = 1; RegWrite_in = 1; ALU_result_in = 32'h410; EX_MEM_RegisterRd_in = 5'd9;
    tick();
    chk("wrap_err_clr", {31'b0, mem_err}, 0);
    tick();
    chk("wrap_rdata", read_data_out, 32'hDEADBEEF);
    chk("wrap_alu", ALU_result_out, 32'h410);

    // Branch / jump resolution
    set_idle();
    Branch_in = 1; ALU_zero_in = 1; branch_addr_in = 32'h40; jump_addr_in = 32'h80;
    #1;
    chk("br_pcsrc", {31'b0, PCSrc_out}, 1);
    chk("br_target", target_addr_out, 32'h40);
    chk("br_jmp", {31'b0, Jump_taken_out}, 0);
    Jump_in = 1;
    #1;
    chk("jmp_taken", {31'b0, Jump_taken_out}, 1);
    chk("jmp_target", target_addr_out, 32'h80);
    Jump_in = 0; ALU_zero_in = 0;
    #1;
    chk("br_nt_pcsrc", {31'b0, PCSrc_out}, 0);
    chk("br_nt_target", target_addr_out, 0);
    ALU_zero_in = 1; Jump_in = 1; MemRead_in = 1; ALU_result_in = 32'h10;
    #1;
    chk("stall_stall", {31'b0, mem_stall}, 1);
    chk("stall_pcsrc", {31'b0, PCSrc_out}, 0);
    chk("stall_jmp", {31'b0, Jump_taken_out}, 0);
    chk("stall_target", target_addr_out, 0);
    tick(); tick();

    // Full store 0x12345678 to 0x20, then an aborted store of 0xCAFEF00D
    set_idle();
    MemWrite_in = 1; ALU_result_in = 32'h20; write_data_in = 32'h12345678;
    tick(); tick();
    set_idle();
    RegWrite_in = 1; ALU_result_in = 32'h55; EX_MEM_RegisterRd_in = 5'd7;
    tick();
    chk("pre_rst_alu", ALU_result_out, 32'h55);
    set_idle();
    MemWrite_in = 1; RegWrite_in = 1; EX_MEM_RegisterRd_in = 5'd7;
    ALU_result_in = 32'h20; write_data_in = 32'hCAFEF00D;
    tick();
    rst = 1;
    tick();
    rst = 0;
    set_idle();
    #1;
    chk("abort_stall", {31'b0, mem_stall}, 0);
    chk("abort_regwr", {31'b0, RegWrite_out}, 0);
    chk("abort_alu", ALU_result_out, 0);
    chk("abort_rd", {27'b0, MEM_WB_RegisterRd_out}, 0);
    chk("abort_rdata", read_data_out, 0);
    MemRead_in = 1; ALU_result_in = 32'h20;
    #1 chk("abort_ld_idle", {31'b0, mem_stall}, 1);
    tick(); tick();
    chk("abort_ram", read_data_out, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
